// File: rtl/vslide_pkg.sv
// Shared types and helpers for the vslide_seq element-slide engine.
package vslide_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int num_elems(input int vlen, input sew_e sew);
    case (sew)
      SEW16:   return vlen / 16;
      SEW32:   return vlen / 32;
      default: return vlen / 8;
    endcase
  endfunction

endpackage

// File: rtl/vslide_elem_sel.sv
// Combinational element access at a given SEW: reads element rd_idx of src
// and returns dst with element wr_idx replaced by wr_data (truncated to SEW).
module vslide_elem_sel
  import vslide_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int IDX_W = 5
) (
  input  logic [1:0]       sew,
  input  logic [VLEN-1:0]  src,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic [VLEN-1:0]  dst,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  output logic [VLEN-1:0]  wr_vec
);

  logic [31:0]     ones;
  logic [31:0]     ew;
  logic [31:0]     rd_sh;
  logic [31:0]     wr_sh;
  logic [VLEN-1:0] emask;

  always_comb begin
    ones = 32'h0000_00ff;
    ew   = 32'd8;
    case (sew_e'(sew))
      SEW16: begin ones = 32'h0000_ffff; ew = 32'd16; end
      SEW32: begin ones = 32'hffff_ffff; ew = 32'd32; end
      default: begin ones = 32'h0000_00ff; ew = 32'd8; end
    endcase
    // Indices past the register shift everything out and read as zero.
    rd_sh   = 32'(rd_idx) * ew;
    wr_sh   = 32'(wr_idx) * ew;
    rd_data = 32'(src >> rd_sh) & ones;
    emask   = VLEN'(ones) << wr_sh;
    wr_vec  = (dst & ~emask) | (VLEN'(wr_data & ones) << wr_sh);
  end

endmodule

// File: rtl/vslide_seq.sv
// Multi-cycle vslideup/vslidedown engine, one element per cycle.
// Optional macro VSLIDE1_EN adds vslide1up/vslide1down (in_slide1, in_scalar).
module vslide_seq
  import vslide_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int OFFSET_W = 32,
  parameter int VL_W     = $clog2(VLEN/8) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_slide_up,
  input  logic [1:0]          in_sew,
  input  logic [OFFSET_W-1:0] in_offset,
  input  logic [VL_W-1:0]     in_vl,
  input  logic [VLEN-1:0]     in_src,
  input  logic [VLEN-1:0]     in_old,
`ifdef VSLIDE1_EN
  input  logic                in_slide1,
  input  logic [31:0]         in_scalar,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VLEN-1:0]     out_result
);

  localparam int CW = OFFSET_W + 1;

  state_e                state;
  logic [VL_W-1:0]       idx;
  logic                  up_q;
  sew_e                  sew_q;
  logic [OFFSET_W-1:0]   off_q;
  logic [VL_W-1:0]       vl_q;
  logic [VLEN-1:0]       src_q;
  logic                  sew_illegal;
`ifdef VSLIDE1_EN
  logic                  slide1_q;
  logic [31:0]           scalar_q;
`endif

  logic [VL_W-1:0]       ne;
  logic [CW-1:0]         i_ext;
  logic [CW-1:0]         off_ext;
  logic [CW-1:0]         down_sum;
  logic [VL_W-1:0]       src_idx;
  logic [31:0]           rd_data;
  logic [31:0]           wdata;
  logic                  wen;
  logic [VLEN-1:0]       wr_vec;

  assign ne       = VL_W'(num_elems(VLEN, sew_q));
  assign i_ext    = CW'(idx);
  assign off_ext  = CW'(off_q);
  assign down_sum = i_ext + off_ext;
  assign src_idx  = up_q ? VL_W'(i_ext - off_ext) : VL_W'(down_sum);

  vslide_elem_sel #(.VLEN(VLEN), .IDX_W(VL_W)) u_sel (
    .sew     (sew_q),
    .src     (src_q),
    .rd_idx  (src_idx),
    .rd_data (rd_data),
    .dst     (out_result),
    .wr_idx  (idx),
    .wr_data (wdata),
    .wr_vec  (wr_vec)
  );

  // Element policy: tail and slide-up prefix keep old, slide-down overrun is zero.
  always_comb begin
    wen   = 1'b0;
    wdata = rd_data;
    if (idx < vl_q) begin
      if (up_q) begin
        if (i_ext >= off_ext) wen = 1'b1;
      end else begin
        wen = 1'b1;
        if (down_sum >= CW'(ne)) wdata = 32'd0;
      end
`ifdef VSLIDE1_EN
      if (slide1_q && up_q && idx == '0) begin
        wen   = 1'b1;
        wdata = scalar_q;
      end else if (slide1_q && !up_q && idx == vl_q - VL_W'(1)) begin
        wen   = 1'b1;
        wdata = scalar_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      up_q        <= 1'b0;
      sew_q       <= SEW8;
      off_q       <= '0;
      vl_q        <= '0;
      src_q       <= '0;
      sew_illegal <= 1'b0;
`ifdef VSLIDE1_EN
      slide1_q    <= 1'b0;
      scalar_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            up_q        <= in_slide_up;
            sew_q       <= (in_sew == 2'b11) ? SEW8 : sew_e'(in_sew);
            sew_illegal <= (in_sew == 2'b11);
            off_q       <= in_offset;
            vl_q        <= in_vl;
            src_q       <= in_src;
            out_result  <= in_old;
            idx         <= '0;
            in_ready    <= 1'b0;
`ifdef VSLIDE1_EN
            slide1_q    <= in_slide1;
            scalar_q    <= in_scalar;
            if (in_slide1) off_q <= OFFSET_W'(1);
`endif
            if (in_vl == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (wen) out_result <= wr_vec;
          idx <= idx + VL_W'(1);
          if (idx == ne - VL_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sew_legal_chk: assert property (@(posedge clk) disable iff (rst) !sew_illegal);

endmodule

// File: tb/tb_vslide_seq.sv
// Directed bench for vslide_seq at VLEN=32 with hand-computed expected results.
module tb_vslide_seq;

  localparam int VLEN     = 32;
  localparam int OFFSET_W = 32;
  localparam int VL_W     = $clog2(VLEN/8) + 1;

  localparam logic [31:0] SRC = 32'h4433_2211;
  localparam logic [31:0] OLD = 32'hDDCC_BBAA;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_slide_up = 1'b0;
  logic [1:0]          in_sew = 2'b00;
  logic [OFFSET_W-1:0] in_offset = '0;
  logic [VL_W-1:0]     in_vl = '0;
  logic [VLEN-1:0]     in_src = SRC;
  logic [VLEN-1:0]     in_old = OLD;
`ifdef VSLIDE1_EN
  logic                in_slide1 = 1'b0;
  logic [31:0]         in_scalar = 32'h0000_005A;
`endif
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [VLEN-1:0]     out_result;

  int checks = 0;
  int errors = 0;

  vslide_seq #(.VLEN(VLEN), .OFFSET_W(OFFSET_W), .VL_W(VL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_slide_up (in_slide_up),
    .in_sew      (in_sew),
    .in_offset   (in_offset),
    .in_vl       (in_vl),
    .in_src      (in_src),
    .in_old      (in_old),
`ifdef VSLIDE1_EN
    .in_slide1   (in_slide1),
    .in_scalar   (in_scalar),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency counting the accept edge as clock 1,
  // optionally hold out_ready low, then complete the output handshake.
  task automatic run_op(input string tag, input logic up, input logic [1:0] sew,
                        input logic [31:0] off, input logic [VL_W-1:0] vl,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_slide_up = up;
    in_sew      = sew;
    in_offset   = off;
    in_vl       = vl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, out_result, exp_res);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_result"}, out_result, exp_res);
      chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({tag, " ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("down_off1_vl4", 1'b0, 2'b00, 32'd1, 3'd4, 32'h0044_3322, 5, 0);
    run_op("up_off2_vl4",   1'b1, 2'b00, 32'd2, 3'd4, 32'h2211_BBAA, 5, 0);
    run_op("down_off1_vl3", 1'b0, 2'b00, 32'd1, 3'd3, 32'hDD44_3322, 5, 0);
    run_op("sew16_down_off7",   1'b0, 2'b01, 32'd7,         3'd2, 32'h0000_0000, 3, 0);
    run_op("sew16_down_offmax", 1'b0, 2'b01, 32'hFFFF_FFFF, 3'd2, 32'h0000_0000, 3, 0);
    run_op("sew16_up_off7",     1'b1, 2'b01, 32'd7,         3'd2, OLD,           3, 0);
    run_op("sew16_up_offmax",   1'b1, 2'b01, 32'hFFFF_FFFF, 3'd2, OLD,           3, 0);
    run_op("sew16_down_off1_vl1", 1'b0, 2'b01, 32'd1, 3'd1, 32'hDDCC_4433, 3, 0);
    run_op("sew32_down_off0", 1'b0, 2'b10, 32'd0, 3'd1, SRC, 2, 0);
    run_op("vl0_backpressure", 1'b0, 2'b00, 32'd1, 3'd0, OLD, 1, 10);

    // Abort an operation mid-RUN with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; in_slide_up = 1'b1; in_sew = 2'b00; in_offset = 32'd1; in_vl = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", 1'b0, 2'b00, 32'd1, 3'd4, 32'h0044_3322, 5, 0);

`ifdef VSLIDE1_EN
    in_slide1 = 1'b1;
    run_op("slide1up",   1'b1, 2'b00, 32'd9, 3'd4, 32'h3322_115A, 5, 0);
    run_op("slide1down", 1'b0, 2'b00, 32'd9, 3'd4, 32'h5A44_3322, 5, 0);
    in_slide1 = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
